// File: rtl/vga_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl_if
// Pixel-fetch bus between the timing controller and a pixel-colour source.
//   pix_x    : requested column 0..H_VALID-1, 11'd1023 when idle
//   pix_y    : requested row 0..V_VALID-1, 11'd1023 when idle
//   pix_data : registered 3-bit colour returned by the source, PIX_LAT
//              cycles after the matching request
// master = timing controller (drives coordinates, receives colour)
// slave  = pixel source      (receives coordinates, drives colour)
// ---------------------------------------------------------------------------
interface vga_timing_ctrl_if;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic [2:0]  pix_data;

   modport master (
      output pix_x,
      output pix_y,
      input  pix_data
   );

   modport slave (
      input  pix_x,
      input  pix_y,
      output pix_data
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// SVGA 800x600@60 timing generator and pixel-fetch controller.
// Free-running horizontal/vertical counters produce coordinate requests
// PIX_LAT cycles ahead of the active window, so the colour returned by the
// pixel source lines up with the registered hsync/vsync/rgb outputs.
// Ports:
//   vga_clk     in   pixel clock (40 MHz)
//   sys_rstn    in   asynchronous active-low reset
//   pix_if      bus  pixel-fetch bus (master): pix_x/pix_y out, pix_data in
//   hsync       out  registered horizontal sync, active level = SYNC_POL
//   vsync       out  registered vertical sync, active level = SYNC_POL
//   rgb         out  registered colour, 0 outside active video
//   frame_start out  one-cycle pulse with the first hsync of a frame
// PIX_LAT must lie in 1..4.
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int H_VALID  = 800,
   parameter int H_FRONT  = 40,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 23,
   parameter int V_VALID  = 600,
   parameter int V_FRONT  = 1,
   parameter int PIX_LAT  = 1,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic               vga_clk,
   input  logic               sys_rstn,
   vga_timing_ctrl_if.master  pix_if,
   output logic               hsync,
   output logic               vsync,
   output logic [2:0]         rgb,
   output logic               frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HS0     = H_SYNC + H_BACK;
   localparam int VS0     = V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
   localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
   // Request window is the active window shifted left by the source latency.
   localparam logic [10:0] REQ_H_FIRST = 11'(HS0 - PIX_LAT);
   localparam logic [10:0] REQ_H_LAST  = 11'(HS0 + H_VALID - 1 - PIX_LAT);
   localparam logic [10:0] ACT_H_FIRST = 11'(HS0);
   localparam logic [10:0] ACT_H_LAST  = 11'(HS0 + H_VALID - 1);
   localparam logic [10:0] ACT_V_FIRST = 11'(VS0);
   localparam logic [10:0] ACT_V_LAST  = 11'(VS0 + V_VALID - 1);
   localparam logic [10:0] COORD_IDLE  = 11'd1023;

   logic [10:0] h_cnt_reg, h_cnt_next;
   logic [10:0] v_cnt_reg, v_cnt_next;
   logic        v_in_win;
   logic        req;
   logic        act;
   logic [10:0] pix_x_next, pix_y_next;

   logic        hsync_reg;
   logic        vsync_reg;
   logic [2:0]  rgb_reg;
   logic        frame_start_reg;

   // ---------------- counters ----------------
   always_comb begin
      h_cnt_next = h_cnt_reg + 11'd1;
      v_cnt_next = v_cnt_reg;
      if (h_cnt_reg == H_LAST) begin
         h_cnt_next = 11'd0;
         v_cnt_next = (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         h_cnt_reg <= 11'd0;
         v_cnt_reg <= 11'd0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   // ---------------- window decode ----------------
   // The subtraction cannot underflow: req already guarantees
   // h_cnt >= REQ_H_FIRST and v_cnt >= ACT_V_FIRST.
   always_comb begin
      v_in_win   = (v_cnt_reg >= ACT_V_FIRST) && (v_cnt_reg <= ACT_V_LAST);
      req        = v_in_win && (h_cnt_reg >= REQ_H_FIRST) && (h_cnt_reg <= REQ_H_LAST);
      act        = v_in_win && (h_cnt_reg >= ACT_H_FIRST) && (h_cnt_reg <= ACT_H_LAST);
      pix_x_next = COORD_IDLE;
      pix_y_next = COORD_IDLE;
      if (req) begin
         pix_x_next = h_cnt_reg - REQ_H_FIRST;
         pix_y_next = v_cnt_reg - ACT_V_FIRST;
      end
   end

   assign pix_if.pix_x = pix_x_next;
   assign pix_if.pix_y = pix_y_next;

   // ---------------- output stage ----------------
   // Everything lags the counters by one cycle, so the colour the source
   // presents while h_cnt = HS0+k (pixel k) is captured into rgb here.
   always_ff @(posedge vga_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         hsync_reg       <= ~SYNC_POL;
         vsync_reg       <= ~SYNC_POL;
         rgb_reg         <= 3'b000;
         frame_start_reg <= 1'b0;
      end else begin
         hsync_reg       <= (h_cnt_reg < H_SYNC_END) ~^ SYNC_POL;
         vsync_reg       <= (v_cnt_reg < V_SYNC_END) ~^ SYNC_POL;
         rgb_reg         <= act ? pix_if.pix_data : 3'b000;
         frame_start_reg <= (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
      end
   end

   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign rgb         = rgb_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Three controllers share one clock and reset:
//   d : default SVGA timing, PIX_LAT=1, source returns pix_x[2:0]
//   a : small timing, PIX_LAT=1, source returns a random colour table
//   b : small timing, PIX_LAT=3, SYNC_POL=0, same colour table
// A reference model derives every output from the number of clock edges
// since reset release, using frame/line arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;
   localparam int CLK_HALF = 5;

   // default SVGA timing
   localparam int D_HS = 128, D_HB = 88, D_HV = 800, D_HF = 40;
   localparam int D_VS = 4,   D_VB = 23, D_VV = 600, D_VF = 1;
   localparam int D_HT = D_HS + D_HB + D_HV + D_HF;   // 1056
   localparam int D_VT = D_VS + D_VB + D_VV + D_VF;   // 628
   // small timing so that many whole frames fit in a short run
   localparam int S_HS = 8, S_HB = 6, S_HV = 20, S_HF = 4;
   localparam int S_VS = 2, S_VB = 3, S_VV = 5,  S_VF = 1;
   localparam int S_HT = S_HS + S_HB + S_HV + S_HF;   // 38
   localparam int S_VT = S_VS + S_VB + S_VV + S_VF;   // 11
   localparam int S_FRAME = S_HT * S_VT;              // 418
   localparam int L27 = 27 * D_HT;                    // first edge count of line 27

   logic vga_clk  = 1'b0;
   logic sys_rstn = 1'b0;
   always #CLK_HALF vga_clk = ~vga_clk;

   vga_timing_ctrl_if bus_d ();
   vga_timing_ctrl_if bus_a ();
   vga_timing_ctrl_if bus_b ();

   logic       hs_d, vs_d, fs_d, hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
   logic [2:0] rgb_d, rgb_a, rgb_b;

   vga_timing_ctrl u_dut_d (
      .vga_clk(vga_clk), .sys_rstn(sys_rstn), .pix_if(bus_d),
      .hsync(hs_d), .vsync(vs_d), .rgb(rgb_d), .frame_start(fs_d)
   );

   vga_timing_ctrl #(
      .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_FRONT(S_HF),
      .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_FRONT(S_VF),
      .PIX_LAT(1), .SYNC_POL(1'b1)
   ) u_dut_a (
      .vga_clk(vga_clk), .sys_rstn(sys_rstn), .pix_if(bus_a),
      .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_start(fs_a)
   );

   vga_timing_ctrl #(
      .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_FRONT(S_HF),
      .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_FRONT(S_VF),
      .PIX_LAT(3), .SYNC_POL(1'b0)
   ) u_dut_b (
      .vga_clk(vga_clk), .sys_rstn(sys_rstn), .pix_if(bus_b),
      .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .frame_start(fs_b)
   );

   // ---------------- pixel sources ----------------
   logic [2:0] colour_tbl [S_HV*S_VV];
   logic [2:0] b_pipe1, b_pipe2;

   function automatic logic [2:0] tbl_colour(input logic [10:0] x, input logic [10:0] y);
      if (int'(x) < S_HV && int'(y) < S_VV)
         return colour_tbl[int'(y) * S_HV + int'(x)];
      return 3'b000;
   endfunction

   always @(posedge vga_clk) begin
      bus_d.pix_data <= bus_d.pix_x[2:0];
      bus_a.pix_data <= tbl_colour(bus_a.pix_x, bus_a.pix_y);
      b_pipe1        <= tbl_colour(bus_b.pix_x, bus_b.pix_y);
      b_pipe2        <= b_pipe1;
      bus_b.pix_data <= b_pipe2;
   end

   // edges since reset release: the only state the model needs
   int n_edges = 0;
   always @(posedge vga_clk or negedge sys_rstn) begin
      if (!sys_rstn) n_edges <= 0;
      else           n_edges <= n_edges + 1;
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string what, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (n=%0d t=%0t)", what, actual, expected, n_edges, $time);
      end
   endtask

   // Reference model. After n edges the counters sit at position n of the
   // frame; the registered outputs describe position n-1.
   task automatic model_check(
      input string tag, input int ht, input int hsw, input int hbp, input int hv,
      input int vt, input int vsw, input int vbp, input int vv, input int lat,
      input bit pol, input bit use_tbl, input int n,
      input logic [10:0] ax, input logic [10:0] ay,
      input logic ahs, input logic avs, input logic afs, input logic [2:0] argb);
      int hs0, vs0, p, q, col, row, ex, ey, ehs, evs, efs, ergb;
      hs0 = hsw + hbp;
      vs0 = vsw + vbp;
      // request: the pixel that will be inside the active window lat cycles later
      p   = n % (ht * vt);
      col = (p % ht) + lat - hs0;
      row = (p / ht) - vs0;
      if (col >= 0 && col < hv && row >= 0 && row < vv) begin
         ex = col; ey = row;
      end else begin
         ex = 1023; ey = 1023;
      end
      if (n == 0) begin
         ehs = int'(!pol); evs = int'(!pol); efs = 0; ergb = 0;
      end else begin
         q    = (n - 1) % (ht * vt);
         ehs  = ((q % ht) < hsw) ? int'(pol) : int'(!pol);
         evs  = ((q / ht) < vsw) ? int'(pol) : int'(!pol);
         efs  = (q == 0) ? 1 : 0;
         col  = (q % ht) - hs0;
         row  = (q / ht) - vs0;
         ergb = 0;
         if (col >= 0 && col < hv && row >= 0 && row < vv)
            ergb = use_tbl ? int'(colour_tbl[row * S_HV + col]) : (col % 8);
      end
      check({tag, ".pix_x"},       int'(ax),   ex);
      check({tag, ".pix_y"},       int'(ay),   ey);
      check({tag, ".hsync"},       int'(ahs),  ehs);
      check({tag, ".vsync"},       int'(avs),  evs);
      check({tag, ".frame_start"}, int'(afs),  efs);
      check({tag, ".rgb"},         int'(argb), ergb);
   endtask

   task automatic check_reset_all();
      check("rst.d.hsync", int'(hs_d), 0);  check("rst.d.vsync", int'(vs_d), 0);
      check("rst.d.rgb", int'(rgb_d), 0);   check("rst.d.frame_start", int'(fs_d), 0);
      check("rst.d.pix_x", int'(bus_d.pix_x), 1023);
      check("rst.d.pix_y", int'(bus_d.pix_y), 1023);
      check("rst.a.hsync", int'(hs_a), 0);  check("rst.a.rgb", int'(rgb_a), 0);
      check("rst.b.hsync", int'(hs_b), 1);  check("rst.b.vsync", int'(vs_b), 1);
      check("rst.b.rgb", int'(rgb_b), 0);   check("rst.b.pix_x", int'(bus_b.pix_x), 1023);
   endtask

   // ---------------- per-cycle compare ----------------
   int last_fs_a = -1;
   int hs_cnt_d  = 0;
   int vs_cnt_a  = 0;

   always @(negedge vga_clk) begin
      model_check("d", D_HT, D_HS, D_HB, D_HV, D_VT, D_VS, D_VB, D_VV, 1, 1'b1, 1'b0,
                  n_edges, bus_d.pix_x, bus_d.pix_y, hs_d, vs_d, fs_d, rgb_d);
      model_check("a", S_HT, S_HS, S_HB, S_HV, S_VT, S_VS, S_VB, S_VV, 1, 1'b1, 1'b1,
                  n_edges, bus_a.pix_x, bus_a.pix_y, hs_a, vs_a, fs_a, rgb_a);
      model_check("b", S_HT, S_HS, S_HB, S_HV, S_VT, S_VS, S_VB, S_VV, 3, 1'b0, 1'b1,
                  n_edges, bus_b.pix_x, bus_b.pix_y, hs_b, vs_b, fs_b, rgb_b);

      // hand-computed points that pin the model
      if (n_edges == 1)   begin check("lit.d.hsync_first", int'(hs_d), 1); check("lit.d.fs_first", int'(fs_d), 1);
                                check("lit.b.hsync_first", int'(hs_b), 0); end
      if (n_edges == 2)   check("lit.d.fs_once", int'(fs_d), 0);
      if (n_edges == 128) check("lit.d.hsync_last", int'(hs_d), 1);
      if (n_edges == 129) check("lit.d.hsync_end", int'(hs_d), 0);
      if (n_edges == 9)   check("lit.b.hsync_end", int'(hs_b), 1);
      if (n_edges == 200) check("lit.b.pix_x_idle", int'(bus_b.pix_x), 1023);
      if (n_edges == 201) begin check("lit.b.pix_x_first", int'(bus_b.pix_x), 0);
                                check("lit.b.pix_y_first", int'(bus_b.pix_y), 0); end
      if (n_edges == 203) check("lit.a.pix_x_first", int'(bus_a.pix_x), 0);
      if (n_edges == L27 + 214) check("lit.d.pix_x_pre", int'(bus_d.pix_x), 1023);
      if (n_edges == L27 + 215) begin check("lit.d.pix_x_0", int'(bus_d.pix_x), 0);
                                      check("lit.d.pix_y_0", int'(bus_d.pix_y), 0); end
      if (n_edges == L27 + 1014) check("lit.d.pix_x_799", int'(bus_d.pix_x), 799);
      if (n_edges == L27 + 1015) check("lit.d.pix_x_post", int'(bus_d.pix_x), 1023);
      if (n_edges == L27 + 218)  check("lit.d.rgb_k1", int'(rgb_d), 1);
      if (n_edges == L27 + 224)  check("lit.d.rgb_k7", int'(rgb_d), 7);
      if (n_edges == L27 + 1016) check("lit.d.rgb_k799", int'(rgb_d), 7);
      if (n_edges == L27 + 1017) check("lit.d.rgb_after", int'(rgb_d), 0);

      // aggregate periods
      if (n_edges == 0) begin
         hs_cnt_d  = 0;
         vs_cnt_a  = 0;
         last_fs_a = -1;
      end else begin
         if (n_edges <= D_HT && hs_d) hs_cnt_d++;
         if (n_edges == D_HT) check("d.hsync_per_line", hs_cnt_d, 128);
         if (n_edges <= S_FRAME && vs_a) vs_cnt_a++;
         if (n_edges == S_FRAME) check("a.vsync_per_frame", vs_cnt_a, S_VS * S_HT);
         if (fs_a) begin
            if (last_fs_a >= 0) check("a.frame_period", n_edges - last_fs_a, S_FRAME);
            last_fs_a = n_edges;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < S_HV * S_VV; i++) colour_tbl[i] = 3'($urandom_range(0, 7));
      sys_rstn = 1'b0;
      repeat (3) @(negedge vga_clk);
      #1 check_reset_all();
      #1 sys_rstn = 1'b1;
      // reach past the end of line 27 on the default-timing controller
      repeat (L27 + 1100) @(posedge vga_clk);
      // random asynchronous resets mid-line
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(40, 900)) @(posedge vga_clk);
         @(negedge vga_clk);
         #2 sys_rstn = 1'b0;
         #1 check_reset_all();
         repeat ($urandom_range(1, 4)) @(negedge vga_clk);
         #2 sys_rstn = 1'b1;
      end
      repeat (2 * S_FRAME + 100) @(posedge vga_clk);
      @(negedge vga_clk);
      #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

SVGA 800×600@60 timing generator and pixel-fetch controller. It runs from the 40 MHz VGA clock and drives pixel coordinate requests (`pix_x`, `pix_y`) to a pixel-colour source such as the analog clock renderer. It takes back that source's registered 3-bit colour (`pix_data`) and emits aligned `hsync`, `vsync` and `rgb` to the DAC/connector pins. Coordinate requests are issued `PIX_LAT` cycles ahead, so returned colour lines up with the active video window.

## Interface
Clock and reset are fixed: one clock, `vga_clk`; reset `sys_rstn` is asynchronous and active-low.

**Parameters**
- `H_SYNC` = 128: hsync width, clocks
- `H_BACK` = 88: horizontal back porch
- `H_VALID` = 800: active pixels per line
- `H_FRONT` = 40: horizontal front porch
- `V_SYNC` = 4: vsync width, lines
- `V_BACK` = 23: vertical back porch
- `V_VALID` = 600: active lines
- `V_FRONT` = 1: vertical front porch
- `PIX_LAT` = 1: pixel-source latency, legal 1..4
- `SYNC_POL` = 1: sync active level (1 = active-high)

**Ports**
- `vga_clk`  in  1  pixel clock, 40 MHz
- `sys_rstn`  in  1  asynchronous active-low reset
- `pix_data`  in  3  colour from pixel source, valid `PIX_LAT` cycles after the matching request
- `pix_x`  out  11  requested column 0..799; 11'd1023 when idle
- `pix_y`  out  11  requested row 0..599; 11'd1023 when idle
- `hsync`  out  1  registered horizontal sync
- `vsync`  out  1  registered vertical sync
- `rgb`  out  3  registered colour to pins; 0 outside active video
- `frame_start`  out  1  one-cycle pulse aligned with first hsync edge of a frame

## Operation
**Counters**
- H_TOTAL = 1056, V_TOTAL = 628 by default.
- `h_cnt` runs 0..H_TOTAL-1 and wraps to 0.
- `v_cnt` increments when `h_cnt` wraps, runs 0..V_TOTAL-1, and wraps to 0.

**Region order per line and per frame:** sync, back porch, valid, front porch.
- HS0 = H_SYNC+H_BACK (216).
- VS0 = V_SYNC+V_BACK (27).

**Request window**
- `req` = (HS0-PIX_LAT ≤ `h_cnt` ≤ HS0+H_VALID-1-PIX_LAT) AND (VS0 ≤ `v_cnt` ≤ VS0+V_VALID-1).
- `pix_x` = `req` ? `h_cnt`-(HS0-PIX_LAT) : 1023.
- `pix_y` = `req` ? `v_cnt`-VS0 : 1023.
- Both are decoded combinationally from the registered counters, so they are glitch-free per cycle.

**Active window**
- `act` = (HS0 ≤ `h_cnt` ≤ HS0+H_VALID-1) AND the same vertical condition.

**Output stage** (all registered on `vga_clk`)
- `hsync` ← (`h_cnt` < H_SYNC) XNOR `SYNC_POL`.
- `vsync` ← (`v_cnt` < V_SYNC) XNOR `SYNC_POL`.
- `rgb` ← `act` ? `pix_data` : 3'b000.
- `frame_start` ← (`h_cnt`==0 && `v_cnt`==0).

**Latency compensation**
- `PIX_LAT` only shifts the request window; nothing else is buffered.
- The `pix_data` presented while `h_cnt` = HS0+k is the colour of pixel k.
- Arithmetic is unsigned 11-bit; no subtraction underflows, because the request window guarantees `h_cnt` ≥ HS0-PIX_LAT.

**Reset (async, any time, including mid-line)**
- `h_cnt` = `v_cnt` = 0.
- `hsync` = `vsync` = ~`SYNC_POL` (0 by default).
- `rgb` = 0, `frame_start` = 0.
- `pix_x` = `pix_y` = 1023.
- The first counted cycle after release is `h_cnt` = 0, `v_cnt` = 0.

## Timing
- Outputs lag the counters by exactly 1 cycle.
- `hsync`, `vsync`, `rgb` and `frame_start` are mutually aligned.
- `hsync` is active for cycles 1..128 after each line start, with a period of 1056 cycles.
- `vsync` is active for 4×1056 cycles, with a period of 628×1056 = 663168 cycles (60.3 Hz).
- `rgb` carries pixel k at `h_cnt` = HS0+k+1 (cycle-relative), 800 consecutive cycles per valid line.
- `frame_start` is high exactly 1 cycle per frame, coincident with the first active `hsync` of line 0.
- Wrap boundaries:
  - `h_cnt` 1055→0 and `v_cnt` 627→0 in the same cycle produce a normal frame start.
  - Front-porch cycles never assert `req`.

## Test plan
- **Reset:** hold `sys_rstn`=0 → `hsync`=`vsync`=0, `rgb`=0, `frame_start`=0, `pix_x`=`pix_y`=1023. Release → `hsync`=1 for exactly 128 cycles starting 1 cycle after the first counted edge; `frame_start` pulses once.
- **Sync periods:** run 2 frames → `hsync` high 128 of every 1056 cycles; `vsync` high 4224 of every 663168 cycles; `frame_start` separation = 663168.
- **Request window (`PIX_LAT`=1):**
  - On line `v_cnt`=27: `pix_x`=0, `pix_y`=0 at `h_cnt`=215; `pix_x`=799 at `h_cnt`=1014; `pix_x`=1023 at `h_cnt`=1015.
  - On line 626: `pix_y`=599.
  - On line 627: `pix_y`=1023 throughout.
- **Alignment:** the bench pixel source registers `pix_data` ← `pix_x[2:0]`. Then `rgb` is 0,1,…,7 repeating for 800 cycles beginning 1 cycle after `h_cnt`=216, and 0 on every other cycle, including all porch and sync cycles.
- **`PIX_LAT`=3 instance:** the source delays `pix_x[2:0]` by 3 stages. Then `pix_x`=0 at `h_cnt`=213, and the `rgb` sequence is identical to the `PIX_LAT`=1 case.
- **Mid-operation reset:** assert `sys_rstn` at `h_cnt`=500, `v_cnt`=100 → all outputs reach reset values without waiting for a clock edge. After release, timing restarts from `h_cnt`=0, `v_cnt`=0, with `frame_start` after 1 cycle.
